mealy_decoder: RTL and testbench

Inverse of the team's 4-state Mealy bit-stream encoder: tracks the encoder state from the received y stream and recovers the original x bits.
- Decoding is lossless. In every state the two x values give different y values, so each y maps to exactly one x.
- Recovered bits are packed LSB-first into WIDTH-bit words and handed downstream on a valid/ready handshake.
- Sits at the receive end of the link that the encoder drives.

---
 rtl/mealy_pkg.sv | 29 ++
 rtl/mealy_dec_core.sv | 49 ++++
 rtl/mealy_decoder.sv | 92 +++++++++
 tb/tb_mealy_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared state encoding and decode helpers for the 4-state Mealy encoder/decoder pair.
package mealy_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // Recovers x from y: y passes through in S0/S3 and is inverted in S1/S2.
    function automatic logic dec_bit(input state_t s, input logic y);
        return (s == S0 || s == S3) ? y : ~y;
    endfunction

    function automatic state_t next_state(input state_t s, input logic y);
        state_t ns;
        ns = S0;
        case (s)
            S0: ns = y ? S0 : S1;
            S1: ns = y ? S2 : S3;
            S2: ns = y ? S0 : S1;
            S3: ns = y ? S2 : S3;
            default: ns = S0;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/mealy_dec_core.sv
// Bit-level tracker of the encoder state; emits the recovered bit combinationally and registered.
// Optional MEALY_DEC_RESYNC_EN adds a resync input that realigns the tracker to S0.
module mealy_dec_core
    import mealy_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef MEALY_DEC_RESYNC_EN
    input  logic resync,
`endif
    input  logic y_in,
    input  logic y_valid,
    output logic x_bit,
    output logic x_fire,
    output logic x_out,
    output logic x_valid
);

    state_t state;
    logic   resync_i;

`ifdef MEALY_DEC_RESYNC_EN
    assign resync_i = resync;
`else
    assign resync_i = 1'b0;
`endif

    // The packer consumes these on the same edge that the bit is registered here.
    assign x_bit  = dec_bit(state, y_in);
    assign x_fire = y_valid & ~resync_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S0;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= x_fire;
            if (resync_i) begin
                state <= S0;
            end else if (x_fire) begin
                state <= next_state(state, y_in);
                x_out <= x_bit;
            end
        end
    end

endmodule

// File: rtl/mealy_decoder.sv
// Mealy stream decoder: recovers x bits and packs them LSB-first into WIDTH-bit words on valid/ready.
// Optional MEALY_DEC_RESYNC_EN adds a resync port that restarts the tracker and the partial word.
module mealy_decoder
    import mealy_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MEALY_DEC_RESYNC_EN
    input  logic             resync,
`endif
    input  logic             y_in,
    input  logic             y_valid,
    output logic             x_out,
    output logic             x_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             x_bit;
    logic             x_fire;
    logic             resync_i;
    logic             word_done;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [CNT_W-1:0] count;

`ifdef MEALY_DEC_RESYNC_EN
    assign resync_i = resync;
`else
    assign resync_i = 1'b0;
`endif

    mealy_dec_core u_core (
        .clk     (clk),
        .rst     (rst),
`ifdef MEALY_DEC_RESYNC_EN
        .resync  (resync),
`endif
        .y_in    (y_in),
        .y_valid (y_valid),
        .x_bit   (x_bit),
        .x_fire  (x_fire),
        .x_out   (x_out),
        .x_valid (x_valid)
    );

    // Shift-and-or keeps the insert position free of index-width issues for any WIDTH.
    assign shift_nxt = shift_q | (WIDTH'(x_bit) << count);
    assign word_done = x_fire && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            count      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (resync_i) begin
                shift_q <= '0;
                count   <= '0;
            end else if (x_fire) begin
                if (word_done) begin
                    shift_q <= '0;
                    count   <= '0;
                end else begin
                    shift_q <= shift_nxt;
                    count   <= count + CNT_W'(1);
                end
            end

            // A completing word replaces an accepted one; one arriving on a stalled word is dropped.
            if (word_done) begin
                if (!word_valid || word_ready) begin
                    word_out   <= shift_nxt;
                    word_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mealy_decoder.sv
// Scoreboard bench for mealy_decoder with WIDTH=4; covers MEALY_DEC_RESYNC_EN when defined.
module tb_mealy_decoder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         y_in = 1'b0;
    logic         y_valid = 1'b0;
    logic         word_ready = 1'b0;
`ifdef MEALY_DEC_RESYNC_EN
    logic         resync = 1'b0;
`endif
    logic         x_out;
    logic         x_valid;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [1:0]   m_state;
    int           m_cnt;
    logic [W-1:0] m_shift;
    logic [W-1:0] m_wo;
    logic         m_wv;
    logic         m_ovf;
    logic         exp_xv;
    logic         x_q[$];

    mealy_decoder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MEALY_DEC_RESYNC_EN
        .resync     (resync),
`endif
        .y_in       (y_in),
        .y_valid    (y_valid),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Decode table written out row by row: {state, y} -> x
    function automatic logic m_x(input logic [1:0] s, input logic y);
        case ({s, y})
            3'b001: return 1'b1;
            3'b000: return 1'b0;
            3'b010: return 1'b1;
            3'b011: return 1'b0;
            3'b100: return 1'b1;
            3'b101: return 1'b0;
            3'b111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_ns(input logic [1:0] s, input logic y);
        case ({s, y})
            3'b001: return 2'd0;
            3'b000: return 2'd1;
            3'b010: return 2'd3;
            3'b011: return 2'd2;
            3'b100: return 2'd1;
            3'b101: return 2'd0;
            3'b111: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 2'd0;
        m_cnt   = 0;
        m_shift = '0;
        m_wo    = '0;
        m_wv    = 1'b0;
        m_ovf   = 1'b0;
        exp_xv  = 1'b0;
        x_q.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        y_valid    = 1'b0;
        word_ready = 1'b0;
`ifdef MEALY_DEC_RESYNC_EN
        resync     = 1'b0;
`endif
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    // Updates the model, drives one cycle of stimulus, and returns 1 time unit after the edge.
    task automatic tick(input logic y, input logic v, input logic rdy, input logic rs);
        logic         b;
        logic         done;
        logic [W-1:0] ns;
        done = 1'b0;
        if (rs) begin
            m_state = 2'd0;
            m_cnt   = 0;
            m_shift = '0;
        end else if (v) begin
            b = m_x(m_state, y);
            x_q.push_back(b);
            ns = m_shift | (W'(b) << m_cnt);
            if (m_cnt == W - 1) begin
                done    = 1'b1;
                m_cnt   = 0;
                m_shift = '0;
                if (!m_wv || rdy) begin
                    m_wo = ns;
                    m_wv = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else begin
                m_cnt   = m_cnt + 1;
                m_shift = ns;
            end
            m_state = m_ns(m_state, y);
        end
        if (!done && m_wv && rdy) m_wv = 1'b0;
        exp_xv = v && !rs;

        y_in       = y;
        y_valid    = v;
        word_ready = rdy;
`ifdef MEALY_DEC_RESYNC_EN
        resync     = rs;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests += 5;
        if (x_out !== 1'b0)      begin n_fail++; $display("FAIL reset_x_out: got %0b expected 0", x_out); end
        if (x_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_x_valid: got %0b expected 0", x_valid); end
        if (word_out !== '0)     begin n_fail++; $display("FAIL reset_word_out: got %0h expected 0", word_out); end
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %0b expected 0", word_valid); end
        if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_decode();
        logic ys[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic xs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(ys[i], 1'b1, 1'b1, 1'b0);
            e = x_q.pop_front();
            n_tests += 4;
            if (x_valid !== 1'b1) begin n_fail++; $display("FAIL decode_x_valid[%0d]: got %0b expected 1", i, x_valid); end
            if (x_out !== e)      begin n_fail++; $display("FAIL decode_x_model[%0d]: got %0b expected %0b", i, x_out, e); end
            if (x_out !== xs[i])  begin n_fail++; $display("FAIL decode_x_table[%0d]: got %0b expected %0b", i, x_out, xs[i]); end
            if (word_valid !== (i == 3)) begin
                n_fail++; $display("FAIL decode_word_valid[%0d]: got %0b expected %0b", i, word_valid, i == 3);
            end
        end
        n_tests += 1;
        if (word_out !== 4'hD) begin n_fail++; $display("FAIL decode_word: got %0h expected d", word_out); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests += 2;
        if (x_valid !== 1'b0)       begin n_fail++; $display("FAIL decode_idle_x_valid: got %0b expected 0", x_valid); end
        if (word_valid !== m_wv)    begin n_fail++; $display("FAIL decode_accept: got %0b expected %0b", word_valid, m_wv); end
    endtask

    task automatic test_gaps();
        logic ys[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(ys[i], (i % 2) == 0, 1'b1, 1'b0);
            n_tests += 1;
            if (x_valid !== exp_xv) begin n_fail++; $display("FAIL gap_x_valid[%0d]: got %0b expected %0b", i, x_valid, exp_xv); end
            if (exp_xv) begin
                e = x_q.pop_front();
                n_tests += 1;
                if (x_out !== e) begin n_fail++; $display("FAIL gap_x[%0d]: got %0b expected %0b", i, x_out, e); end
            end
            n_tests += 1;
            if (word_valid !== m_wv) begin n_fail++; $display("FAIL gap_word_valid[%0d]: got %0b expected %0b", i, word_valid, m_wv); end
        end
        n_tests += 1;
        if (word_out !== m_wo) begin n_fail++; $display("FAIL gap_word: got %0h expected %0h", word_out, m_wo); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] first;
        logic         y;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            y = 1'($urandom_range(0, 1));
            tick(y, 1'b1, 1'b0, 1'b0);
            void'(x_q.pop_front());
            if (i == 3) first = m_wo;
            n_tests += 3;
            if (word_valid !== m_wv) begin n_fail++; $display("FAIL ovf_word_valid[%0d]: got %0b expected %0b", i, word_valid, m_wv); end
            if (overflow !== m_ovf)  begin n_fail++; $display("FAIL ovf_flag[%0d]: got %0b expected %0b", i, overflow, m_ovf); end
            if (m_wv && word_out !== m_wo) begin n_fail++; $display("FAIL ovf_word[%0d]: got %0h expected %0h", i, word_out, m_wo); end
        end
        n_tests += 2;
        if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
        if (word_out !== first) begin n_fail++; $display("FAIL ovf_held: got %0h expected %0h", word_out, first); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests += 2;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_accept: got %0b expected 0", word_valid); end
        if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_back_to_back();
        logic y;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            y = 1'($urandom_range(0, 1));
            tick(y, 1'b1, i == 7, 1'b0);
            void'(x_q.pop_front());
        end
        n_tests += 4;
        if (word_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b expected 1", word_valid); end
        if (overflow !== 1'b0)   begin n_fail++; $display("FAIL b2b_overflow: got %0b expected 0", overflow); end
        if (word_out !== m_wo)   begin n_fail++; $display("FAIL b2b_word: got %0h expected %0h", word_out, m_wo); end
        if (m_wv !== 1'b1 || m_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_model: got %0b%0b expected 10", m_wv, m_ovf); end
    endtask

    task automatic test_async_reset();
        logic ys[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_tests += 5;
        if (x_out !== 1'b0)      begin n_fail++; $display("FAIL arst_x_out: got %0b expected 0", x_out); end
        if (x_valid !== 1'b0)    begin n_fail++; $display("FAIL arst_x_valid: got %0b expected 0", x_valid); end
        if (word_out !== '0)     begin n_fail++; $display("FAIL arst_word_out: got %0h expected 0", word_out); end
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL arst_word_valid: got %0b expected 0", word_valid); end
        if (overflow !== 1'b0)   begin n_fail++; $display("FAIL arst_overflow: got %0b expected 0", overflow); end
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick(ys[i], 1'b1, 1'b0, 1'b0);
            void'(x_q.pop_front());
            n_tests += 1;
            if (word_valid !== (i == 3)) begin n_fail++; $display("FAIL arst_fresh_valid[%0d]: got %0b expected %0b", i, word_valid, i == 3); end
        end
        n_tests += 1;
        if (word_out !== m_wo) begin n_fail++; $display("FAIL arst_fresh_word: got %0h expected %0h", word_out, m_wo); end
    endtask

`ifdef MEALY_DEC_RESYNC_EN
    task automatic test_resync();
        logic ys[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic e;
        do_reset();
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        x_q.delete();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        n_tests += 1;
        if (x_valid !== 1'b0) begin n_fail++; $display("FAIL resync_x_valid: got %0b expected 0", x_valid); end
        for (int i = 0; i < 4; i++) begin
            tick(ys[i], 1'b1, 1'b1, 1'b0);
            e = x_q.pop_front();
            n_tests += 2;
            if (x_out !== e) begin n_fail++; $display("FAIL resync_x[%0d]: got %0b expected %0b", i, x_out, e); end
            if (word_valid !== (i == 3)) begin n_fail++; $display("FAIL resync_count[%0d]: got %0b expected %0b", i, word_valid, i == 3); end
            if (i == 0) begin
                n_tests += 1;
                if (x_out !== 1'b1) begin n_fail++; $display("FAIL resync_first: got %0b expected 1", x_out); end
            end
        end
        n_tests += 1;
        if (word_out !== m_wo) begin n_fail++; $display("FAIL resync_word: got %0h expected %0h", word_out, m_wo); end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_gaps();
        test_overflow();
        test_back_to_back();
        test_async_reset();
`ifdef MEALY_DEC_RESYNC_EN
        test_resync();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
